// File: rtl/hilo_mult_ctrl_if.sv
// Operation-request and multiplier-side bus of hilo_mult_ctrl.
//   master : control unit / multiplier side (drives requests and product words)
//   slave  : hilo_mult_ctrl (drives ready, multiplier launch, HI/LO and read results)
// Signals:
//   op_valid/op_sel/rs_val/rt_val : operation request and operands
//   op_ready                      : request accepted on an edge when op_valid && op_ready
//   mul_start/mul_x/mul_y         : launch pulse and held operands to the multiplier
//   mul_high/mul_low              : multiplier product words
//   hi/lo                         : architectural HI/LO registers
//   rd_data/rd_valid              : MFHI/MFLO result and its one-cycle qualifier
//   mult_done                     : one-cycle pulse after HI/LO take a new product
interface hilo_mult_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_sel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        op_ready;
  logic        mul_start;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [31:0] mul_high;
  logic [31:0] mul_low;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        mult_done;

  modport master (
    output op_valid, op_sel, rs_val, rt_val, mul_high, mul_low,
    input  op_ready, mul_start, mul_x, mul_y, hi, lo, rd_data, rd_valid, mult_done
  );

  modport slave (
    input  op_valid, op_sel, rs_val, rt_val, mul_high, mul_low,
    output op_ready, mul_start, mul_x, mul_y, hi, lo, rd_data, rd_valid, mult_done
  );
endinterface

// File: rtl/hilo_mult_ctrl.sv
// HI/LO register file and sequencer for a fixed-latency signed 32x32 multiplier.
// Accepts MULT/MFHI/MFLO/MTHI/MTLO, launches the multiplier with held operands, captures the
// product on the single cycle it is valid and stalls further ops while a multiply is in flight.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : hilo_mult_ctrl_if.slave (request handshake, multiplier link, HI/LO, read results)
module hilo_mult_ctrl #(
  parameter int unsigned MUL_LAT = 34
) (
  input  logic             clk,
  input  logic             rst,
  hilo_mult_ctrl_if.slave  bus
);

  localparam logic [2:0] OpMult = 3'b000;
  localparam logic [2:0] OpMfhi = 3'b001;
  localparam logic [2:0] OpMflo = 3'b010;
  localparam logic [2:0] OpMthi = 3'b011;
  localparam logic [2:0] OpMtlo = 3'b100;

  // Counter value of the cycle in which the product is valid.
  localparam logic [5:0] CapCnt = 6'(MUL_LAT);

  typedef enum logic {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        mul_start_q, mul_start_d;
  logic [31:0] mul_x_q, mul_x_d;
  logic [31:0] mul_y_q, mul_y_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        mult_done_q, mult_done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_start_d = 1'b0;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    mult_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.op_valid) begin
          case (bus.op_sel)
            OpMult: begin
              mul_x_d     = bus.rs_val;
              mul_y_d     = bus.rt_val;
              cnt_d       = 6'd0;
              mul_start_d = 1'b1;
              state_d     = StWait;
            end
            OpMfhi: begin
              rd_data_d  = hi_q;
              rd_valid_d = 1'b1;
            end
            OpMflo: begin
              rd_data_d  = lo_q;
              rd_valid_d = 1'b1;
            end
            OpMthi: hi_d = bus.rs_val;
            OpMtlo: lo_d = bus.rs_val;
            default: ; // unused codes are consumed with no effect
          endcase
        end
      end
      StWait: begin
        // The multiplier clears its outputs one cycle after this, so capture exactly here.
        if (cnt_q == CapCnt) begin
          hi_d        = bus.mul_high;
          lo_d        = bus.mul_low;
          mult_done_d = 1'b1;
          cnt_d       = 6'd0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      mul_start_q <= 1'b0;
      mul_x_q     <= 32'd0;
      mul_y_q     <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      rd_data_q   <= 32'd0;
      rd_valid_q  <= 1'b0;
      mult_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_start_q <= mul_start_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      mult_done_q <= mult_done_d;
    end
  end

  assign bus.op_ready  = (state_q == StIdle);
  assign bus.mul_start = mul_start_q;
  assign bus.mul_x     = mul_x_q;
  assign bus.mul_y     = mul_y_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.mult_done = mult_done_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed self-checking bench for hilo_mult_ctrl, with a behavioural fixed-latency multiplier
// that presents the product only in its valid cycle and junk otherwise.
module tb_hilo_mult_ctrl;

  localparam int unsigned MulLat = 34;

  localparam logic [2:0] OpMult = 3'b000;
  localparam logic [2:0] OpMfhi = 3'b001;
  localparam logic [2:0] OpMflo = 3'b010;
  localparam logic [2:0] OpMthi = 3'b011;
  localparam logic [2:0] OpMtlo = 3'b100;
  localparam logic [2:0] OpNone = 3'b111;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hilo_mult_ctrl_if bus ();

  hilo_mult_ctrl #(.MUL_LAT(MulLat)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: start sampled in cycle k=0, product valid only in cycle k=MulLat.
  logic        mdl_active;
  int          mdl_cnt;
  logic [63:0] mdl_prod;

  initial begin
    mdl_active   = 1'b0;
    mdl_cnt      = 0;
    mdl_prod     = '0;
    bus.mul_high = 32'hDEAD_BEEF;
    bus.mul_low  = 32'hBAAD_F00D;
  end

  always @(negedge rst) mdl_active = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst && bus.mul_start) begin
      mdl_active = 1'b1;
      mdl_cnt    = 0;
      mdl_prod   = $signed({{32{bus.mul_x[31]}}, bus.mul_x}) *
                   $signed({{32{bus.mul_y[31]}}, bus.mul_y});
    end else if (mdl_active) begin
      mdl_cnt++;
    end
    if (rst && mdl_active && mdl_cnt == MulLat) begin
      bus.mul_high = mdl_prod[63:32];
      bus.mul_low  = mdl_prod[31:0];
    end else begin
      bus.mul_high = 32'hDEAD_BEEF;
      bus.mul_low  = 32'hBAAD_F00D;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op and holds it until accepted; returns with time just after the accept edge.
  task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                       output int waits);
    logic rdy;
    bus.op_valid = 1'b1;
    bus.op_sel   = sel;
    bus.rs_val   = a;
    bus.rt_val   = b;
    waits        = 0;
    for (int i = 0; i < 200; i++) begin
      rdy = bus.op_ready;
      tick();
      if (rdy) break;
      waits++;
    end
    bus.op_valid = 1'b0;
  endtask

  // Issues a MULT from idle and follows it to the first ready cycle.
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
    int   w;
    int   busy;
    int   starts;
    logic first_start;
    logic hold_ok;
    issue(OpMult, a, b, w);
    check({tag, "_acc_wait"}, 32'(w), 32'd0);
    busy        = 0;
    starts      = 0;
    hold_ok     = 1'b1;
    first_start = bus.mul_start;
    for (int i = 0; i < 100; i++) begin
      if (bus.op_ready) break;
      busy++;
      if (bus.mul_start) starts++;
      if (bus.mul_x !== a || bus.mul_y !== b) hold_ok = 1'b0;
      tick();
    end
    check({tag, "_first_start"}, 32'(first_start), 32'd1);
    check({tag, "_start_cycles"}, 32'(starts), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy), 32'd35);
    check({tag, "_xy_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_done"}, 32'(bus.mult_done), 32'd1);
    check({tag, "_hi"}, bus.hi, eh);
    check({tag, "_lo"}, bus.lo, el);
  endtask

  initial begin
    int w;
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_sel   = 3'b000;
    bus.rs_val   = '0;
    bus.rt_val   = '0;

    // Reset state
    #12;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_ready", 32'(bus.op_ready), 32'd1);
    check("rst_start", 32'(bus.mul_start), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_done", 32'(bus.mult_done), 32'd0);
    check("rst_mul_x", bus.mul_x, 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    #10;
    rst = 1'b1;
    tick();

    // Signed multiply: 7 * -3 = -21
    run_mult("smul", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    tick();
    check("smul_done_drop", 32'(bus.mult_done), 32'd0);

    // Extreme operands: (-2^31)^2 = 2^62
    run_mult("xmul", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    tick();

    // Stalled MFLO presented 3 cycles into a multiply
    issue(OpMult, 32'd1000, 32'd1000, w);
    tick();
    tick();
    tick();
    issue(OpMflo, 32'd0, 32'd0, w);
    check("stall_waits", 32'(w), 32'd32);
    check("stall_rd_data", bus.rd_data, 32'h000F_4240);
    check("stall_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("stall_hi", bus.hi, 32'd0);
    tick();
    check("stall_rd_valid_drop", 32'(bus.rd_valid), 32'd0);

    // Register moves with no stalls
    issue(OpMthi, 32'h1234_5678, 32'd0, w);
    check("mthi_wait", 32'(w), 32'd0);
    check("mthi_hi", bus.hi, 32'h1234_5678);
    check("mthi_ready", 32'(bus.op_ready), 32'd1);
    issue(OpMtlo, 32'h9ABC_DEF0, 32'd0, w);
    check("mtlo_wait", 32'(w), 32'd0);
    check("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", bus.hi, 32'h1234_5678);
    issue(OpMfhi, 32'd0, 32'd0, w);
    check("mfhi_wait", 32'(w), 32'd0);
    check("mfhi_data", bus.rd_data, 32'h1234_5678);
    check("mfhi_valid", 32'(bus.rd_valid), 32'd1);
    issue(OpMflo, 32'd0, 32'd0, w);
    check("mflo_wait", 32'(w), 32'd0);
    check("mflo_data", bus.rd_data, 32'h9ABC_DEF0);
    check("mflo_valid", 32'(bus.rd_valid), 32'd1);
    check("mflo_ready", 32'(bus.op_ready), 32'd1);
    tick();

    // Reset mid-multiply at cnt==10
    issue(OpMult, 32'h0000_1234, 32'h0000_0010, w);
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", 32'(bus.op_ready), 32'd0);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_hi", bus.hi, 32'd0);
    check("mid_rst_lo", bus.lo, 32'd0);
    check("mid_rst_start", 32'(bus.mul_start), 32'd0);
    check("mid_rst_ready", 32'(bus.op_ready), 32'd1);
    check("mid_rst_mul_x", bus.mul_x, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    run_mult("post_rst", 32'd2, 32'd3, 32'd0, 32'd6);

    // Back-to-back: -1 * -1, then 5 * 6 issued in the first ready cycle
    tick();
    run_mult("b2b_a", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
    run_mult("b2b_b", 32'd5, 32'd6, 32'd0, 32'd30);

    // Unused op code consumed in idle, no effect
    issue(OpNone, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
    check("nop_wait", 32'(w), 32'd0);
    check("nop_ready", 32'(bus.op_ready), 32'd1);
    check("nop_start", 32'(bus.mul_start), 32'd0);
    check("nop_rd_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    check("nop_hi", bus.hi, 32'd0);
    check("nop_lo", bus.lo, 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
